// File: rtl/pipo_rr_arbiter_if.sv
// ============================================================================
// Module      : pipo_rr_arbiter_if
// Description : Request/data/grant bundle between two writers and the shared
//               PIPO register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipo_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] dataout;
    logic             out_valid;

    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, dataout, out_valid
    );

    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, dataout, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/pipo_rr_arbiter.sv
// ============================================================================
// Module      : pipo_rr_arbiter
// Description : Two-writer round-robin arbiter owning a WIDTH-bit PIPO register;
//               winner's word is loaded at its grant edge, held HOLD_CYCLES max.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipo_rr_arbiter #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    pipo_rr_arbiter_if.slave   bus
);

    localparam int              CNT_W       = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;     // 1: requester 1 owned last, so requester 0 wins the next tie
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_valid;
    logic [WIDTH-1:0] r_dout;

    logic w_owner_req;
    logic w_arb;
    logic w_win0;
    logic w_win1;

    assign w_owner_req = r_gnt0 ? bus.req0 : bus.req1;
    assign w_arb       = (r_state == S_IDLE) || (r_cnt == '0) || !w_owner_req;
    assign w_win0      = bus.req0 && (!bus.req1 || r_last);
    assign w_win1      = bus.req1 && (!bus.req0 || !r_last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else if (w_arb) begin
            if (w_win0) begin
                r_state <= S_HOLD;
                r_cnt   <= c_HOLD_LAST;
                r_last  <= 1'b0;
                r_gnt0  <= 1'b1;
                r_gnt1  <= 1'b0;
                r_valid <= 1'b1;
                r_dout  <= bus.data0;
            end else if (w_win1) begin
                r_state <= S_HOLD;
                r_cnt   <= c_HOLD_LAST;
                r_last  <= 1'b1;
                r_gnt0  <= 1'b0;
                r_gnt1  <= 1'b1;
                r_valid <= 1'b1;
                r_dout  <= bus.data1;
            end else begin
                // Nobody asking: release ownership but keep the last word visible.
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_gnt0  <= 1'b0;
                r_gnt1  <= 1'b0;
                r_valid <= 1'b0;
            end
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.out_valid = r_valid;
    assign bus.dataout   = r_dout;

endmodule

`default_nettype wire
